// File: rtl/pose_iter_ctrl_pkg.sv
// pose_iter_ctrl_pkg: shared fixed-point constants, pose type and controller state encoding for
// the coarse-to-fine pose iteration loop.
//   POSE_BW       - width of one pose element (signed fixed point)
//   MUL           - fractional bits; POSE_ONE = 1 << MUL
//   pose_t        - 3x4 row-major pose, element 0 in the least-significant slot
//   IDENTITY_POSE - identity rotation, zero translation
//   iter_state_e  - iteration controller states
package pose_iter_ctrl_pkg;

   localparam int unsigned POSE_BW  = 32;
   localparam int unsigned MUL      = 24;
   localparam int unsigned POSE_NUM = 12;

   localparam logic [POSE_BW-1:0] POSE_ONE = POSE_BW'(1) << MUL;

   typedef logic [POSE_NUM-1:0][POSE_BW-1:0] pose_t;

   function automatic pose_t identity_pose();
      pose_t p;
      p     = '0;
      p[0]  = POSE_ONE;
      p[5]  = POSE_ONE;
      p[10] = POSE_ONE;
      return p;
   endfunction

   localparam pose_t IDENTITY_POSE = identity_pose();

   typedef enum logic [2:0] {
      StIdle,
      StSolve,
      StWaitSolve,
      StUpdate,
      StWaitUpd,
      StCheck,
      StDone
   } iter_state_e;

endpackage

// File: rtl/pose_iter_ctrl_conv_check.sv
// pose_conv_check: combinational convergence test on a delta pose.
//   i_delta      - delta pose
//   i_trans_thr  - translation threshold (unsigned magnitude)
//   i_rot_thr    - rotation-diagonal threshold (unsigned magnitude)
//   o_converged  - all |t| < i_trans_thr and all |diag - ONE| < i_rot_thr
module pose_conv_check
   import pose_iter_ctrl_pkg::*;
(
   input  pose_t              i_delta,
   input  logic [POSE_BW-1:0] i_trans_thr,
   input  logic [POSE_BW-1:0] i_rot_thr,
   output logic               o_converged
);

   localparam int unsigned MAG_BW = POSE_BW + 1;

   // |a - b| for signed operands, evaluated one bit wider so neither the
   // difference nor its negation can wrap.
   function automatic logic [MAG_BW-1:0] abs_diff(input logic [POSE_BW-1:0] a,
                                                  input logic [POSE_BW-1:0] b);
      logic signed [MAG_BW-1:0] sa;
      logic signed [MAG_BW-1:0] sb;
      logic signed [MAG_BW-1:0] d;
      sa = {a[POSE_BW-1], a};
      sb = {b[POSE_BW-1], b};
      d  = sa - sb;
      return d[MAG_BW-1] ? MAG_BW'(-d) : MAG_BW'(d);
   endfunction

   always_comb begin
      o_converged = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (abs_diff(i_delta[4*k+3], POSE_BW'(0)) >= {1'b0, i_trans_thr}) begin
            o_converged = 1'b0;
         end
         if (abs_diff(i_delta[5*k], POSE_ONE) >= {1'b0, i_rot_thr}) begin
            o_converged = 1'b0;
         end
      end
   end

endmodule

// File: rtl/pose_iter_ctrl.sv
// pose_iter_ctrl: coarse-to-fine pose iteration controller. Owns the current pose, runs the
// solver and UpdatePose engines level by level (NUM_LEVEL-1 down to 0) and decides whether to
// iterate, descend or finish.
// Optional feature: define POSE_CONV_CHECK_EN to enable early exit per level on convergence.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   begin frame (accepted only when idle)
//   i_init_pose, i_max_iter   frame configuration, captured on accepted start
//   i_trans_thr, i_rot_thr    convergence thresholds, captured on accepted start
//   o_solve_start/level       solver kick pulse and current pyramid level
//   i_solve_done/fail         solver result strobe and degenerate flag
//   i_delta_pose              solver delta, valid with i_solve_done
//   o_upd_start, o_upd_delta  UpdatePose kick pulse and latched delta
//   i_upd_done, i_upd_pose    UpdatePose done strobe and composed pose
//   o_cur_pose                current pose register
//   o_busy, o_done            busy level, frame-complete pulse
//   o_iter_total              updates performed this frame (saturating)
module pose_iter_ctrl
   import pose_iter_ctrl_pkg::*;
#(
   parameter int unsigned NUM_LEVEL = 3,
   parameter int unsigned ITER_BW   = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_start,
   input  pose_t                        i_init_pose,
   input  logic [ITER_BW-1:0]           i_max_iter,
   input  logic [POSE_BW-1:0]           i_trans_thr,
   input  logic [POSE_BW-1:0]           i_rot_thr,
   output logic                         o_solve_start,
   output logic [$clog2(NUM_LEVEL)-1:0] o_solve_level,
   output pose_t                        o_cur_pose,
   input  logic                         i_solve_done,
   input  logic                         i_solve_fail,
   input  pose_t                        i_delta_pose,
   output logic                         o_upd_start,
   output pose_t                        o_upd_delta,
   input  logic                         i_upd_done,
   input  pose_t                        i_upd_pose,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [7:0]                   o_iter_total
);

   localparam int unsigned LVL_BW = $clog2(NUM_LEVEL);

   iter_state_e        state_q, state_d;
   logic [LVL_BW-1:0]  level_q, level_d;
   logic [ITER_BW-1:0] iter_q, iter_d;
   logic [ITER_BW-1:0] max_iter_q, max_iter_d;
   logic [7:0]         total_q, total_d;
   pose_t              pose_q, pose_d;
   pose_t              delta_q, delta_d;
   logic               solve_start_q, upd_start_q, done_q, busy_q;
   logic               converged;
   logic               advance;
   logic               accept_start;

   assign accept_start = (state_q == StIdle) && i_start;

`ifdef POSE_CONV_CHECK_EN
   logic [POSE_BW-1:0] trans_thr_q, rot_thr_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         trans_thr_q <= '0;
         rot_thr_q   <= '0;
      end else if (accept_start) begin
         trans_thr_q <= i_trans_thr;
         rot_thr_q   <= i_rot_thr;
      end
   end

   pose_conv_check u_conv_check (
      .i_delta     (delta_q),
      .i_trans_thr (trans_thr_q),
      .i_rot_thr   (rot_thr_q),
      .o_converged (converged)
   );
`else
   logic unused_thr;
   assign unused_thr = ^{i_trans_thr, i_rot_thr};
   assign converged  = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      iter_d     = iter_q;
      max_iter_d = max_iter_q;
      total_d    = total_q;
      pose_d     = pose_q;
      delta_d    = delta_q;
      advance    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               pose_d     = i_init_pose;
               max_iter_d = i_max_iter;
               level_d    = LVL_BW'(NUM_LEVEL - 1);
               iter_d     = '0;
               total_d    = '0;
               state_d    = (i_max_iter == '0) ? StDone : StSolve;
            end
         end
         StSolve: state_d = StWaitSolve;
         StWaitSolve: begin
            if (i_solve_done) begin
               if (i_solve_fail) begin
                  advance = 1'b1;
               end else begin
                  delta_d = i_delta_pose;
                  state_d = StUpdate;
               end
            end
         end
         StUpdate: state_d = StWaitUpd;
         StWaitUpd: begin
            if (i_upd_done) begin
               pose_d  = i_upd_pose;
               iter_d  = iter_q + 1'b1;
               total_d = (total_q == 8'hff) ? total_q : total_q + 8'd1;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (converged || (iter_q == max_iter_q)) begin
               advance = 1'b1;
            end else begin
               state_d = StSolve;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Shared by degenerate-solve and end-of-level exits.
      if (advance) begin
         if (level_q == '0) begin
            state_d = StDone;
         end else begin
            level_d = level_q - 1'b1;
            iter_d  = '0;
            state_d = StSolve;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= StIdle;
         level_q       <= '0;
         iter_q        <= '0;
         max_iter_q    <= '0;
         total_q       <= '0;
         pose_q        <= '0;
         delta_q       <= '0;
         solve_start_q <= 1'b0;
         upd_start_q   <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         level_q       <= level_d;
         iter_q        <= iter_d;
         max_iter_q    <= max_iter_d;
         total_q       <= total_d;
         pose_q        <= pose_d;
         delta_q       <= delta_d;
         // Pulses are decoded from the next state so they coincide with the state itself.
         solve_start_q <= (state_d == StSolve);
         upd_start_q   <= (state_d == StUpdate);
         done_q        <= (state_d == StDone);
         busy_q        <= (state_d != StIdle);
      end
   end

   assign o_solve_start = solve_start_q;
   assign o_solve_level = level_q;
   assign o_cur_pose    = pose_q;
   assign o_upd_start   = upd_start_q;
   assign o_upd_delta   = delta_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_iter_total  = total_q;

endmodule

// File: tb/tb_pose_iter_ctrl.sv
module tb_pose_iter_ctrl;
   import pose_iter_ctrl_pkg::*;

   localparam int unsigned NUM_LEVEL = 3;
   localparam int unsigned ITER_BW   = 4;
   localparam int          RSP_N     = 64;
`ifdef POSE_CONV_CHECK_EN
   localparam bit CONV_EN = 1'b1;
`else
   localparam bit CONV_EN = 1'b0;
`endif

   logic               i_clk;
   logic               i_rst_n;
   logic               i_start;
   pose_t              i_init_pose;
   logic [ITER_BW-1:0] i_max_iter;
   logic [POSE_BW-1:0] i_trans_thr;
   logic [POSE_BW-1:0] i_rot_thr;
   logic               o_solve_start;
   logic [1:0]         o_solve_level;
   pose_t              o_cur_pose;
   logic               i_solve_done;
   logic               i_solve_fail;
   pose_t              i_delta_pose;
   logic               o_upd_start;
   pose_t              o_upd_delta;
   logic               i_upd_done;
   pose_t              i_upd_pose;
   logic               o_busy;
   logic               o_done;
   logic [7:0]         o_iter_total;

   pose_iter_ctrl #(
      .NUM_LEVEL (NUM_LEVEL),
      .ITER_BW   (ITER_BW)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_init_pose   (i_init_pose),
      .i_max_iter    (i_max_iter),
      .i_trans_thr   (i_trans_thr),
      .i_rot_thr     (i_rot_thr),
      .o_solve_start (o_solve_start),
      .o_solve_level (o_solve_level),
      .o_cur_pose    (o_cur_pose),
      .i_solve_done  (i_solve_done),
      .i_solve_fail  (i_solve_fail),
      .i_delta_pose  (i_delta_pose),
      .o_upd_start   (o_upd_start),
      .o_upd_delta   (o_upd_delta),
      .i_upd_done    (i_upd_done),
      .i_upd_pose    (i_upd_pose),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_iter_total  (o_iter_total)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int    n_cmp = 0;
   int    n_err = 0;
   string scen  = "";

   // Frame configuration and pre-drawn solver / UpdatePose responses, consumed in order.
   logic [ITER_BW-1:0] cfg_max_iter;
   logic [POSE_BW-1:0] cfg_trans, cfg_rot;
   pose_t              cfg_init;
   bit                 rsp_fail  [RSP_N];
   pose_t              rsp_delta [RSP_N];
   pose_t              rsp_pose  [RSP_N];

   // Model results.
   int    exp_lvl [$];
   bit    exp_upd [$];
   int    exp_total;
   pose_t exp_pose;

   task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s/%s: got %0h expected %0h", scen, tag, obs, exp);
      end
   endtask

   function automatic pose_t rand_pose();
      pose_t p;
      for (int i = 0; i < 12; i++) p[i] = $urandom;
      return p;
   endfunction

   function automatic pose_t stub_delta();
      pose_t p;
      p    = IDENTITY_POSE;
      p[3] = 32'd5;
      return p;
   endfunction

   function automatic pose_t near_identity();
      pose_t p;
      int    s;
      p = rand_pose();
      for (int k = 0; k < 3; k++) begin
         s          = $urandom_range(0, 40) - 20;
         p[5*k]     = POSE_ONE + POSE_BW'(s);
         s          = $urandom_range(0, 40) - 20;
         p[4*k+3]   = POSE_BW'(s);
      end
      return p;
   endfunction

   function automatic bit model_conv(input pose_t d);
      longint v;
      bit     ok;
      ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         v = longint'($signed(d[4*k+3]));
         if (v < 0) v = -v;
         if (v >= longint'(cfg_trans)) ok = 1'b0;
         v = longint'($signed(d[5*k])) - (longint'(1) << MUL);
         if (v < 0) v = -v;
         if (v >= longint'(cfg_rot)) ok = 1'b0;
      end
      return CONV_EN && ok;
   endfunction

   // Expected event list: per level, solve until failure, convergence or the iteration cap.
   task automatic build_expect();
      int r;
      int it;
      exp_lvl.delete();
      exp_upd.delete();
      exp_total = 0;
      exp_pose  = cfg_init;
      r         = 0;
      if (cfg_max_iter != 0) begin
         for (int lvl = NUM_LEVEL - 1; lvl >= 0; lvl--) begin
            it = 0;
            while (1) begin
               exp_lvl.push_back(lvl);
               exp_upd.push_back(!rsp_fail[r]);
               if (rsp_fail[r]) begin
                  r++;
                  break;
               end
               exp_pose = rsp_pose[r];
               it++;
               if (exp_total < 255) exp_total++;
               if (model_conv(rsp_delta[r]) || (it == int'(cfg_max_iter))) begin
                  r++;
                  break;
               end
               r++;
            end
         end
      end
   endtask

   task automatic fill_rsp(input bit directed, input int fail_pct);
      for (int i = 0; i < RSP_N; i++) begin
         rsp_fail[i]  = ($urandom_range(0, 99) < fail_pct);
         rsp_delta[i] = directed ? stub_delta() : near_identity();
         rsp_pose[i]  = rand_pose();
      end
   endtask

   // Drives one frame with the solver/UpdatePose stubs and checks cycle-exact timing.
   task automatic run_frame();
      pose_t cur;
      int    d;
      build_expect();
      cur         = cfg_init;
      i_init_pose = cfg_init;
      i_max_iter  = cfg_max_iter;
      i_trans_thr = cfg_trans;
      i_rot_thr   = cfg_rot;
      i_start     = 1'b1;
      @(negedge i_clk);
      i_start     = 1'b0;
      i_init_pose = rand_pose();
      i_max_iter  = ITER_BW'($urandom);
      chk("busy_after_start", o_busy, 1);
      for (int k = 0; k < exp_lvl.size(); k++) begin
         chk("solve_start", o_solve_start, 1);
         chk("solve_level", o_solve_level, exp_lvl[k]);
         chk("pose_at_solve", o_cur_pose, cur);
         d = $urandom_range(1, 3);
         for (int w = 0; w < d; w++) begin
            i_upd_done = 1'b1;
            i_upd_pose = rand_pose();
            i_start    = ($urandom_range(0, 1) == 1);
            @(negedge i_clk);
            i_upd_done = 1'b0;
            i_start    = 1'b0;
         end
         i_solve_done = 1'b1;
         i_solve_fail = rsp_fail[k];
         i_delta_pose = rsp_delta[k];
         @(negedge i_clk);
         i_solve_done = 1'b0;
         i_solve_fail = 1'b0;
         i_delta_pose = rand_pose();
         if (exp_upd[k]) begin
            chk("upd_start", o_upd_start, 1);
            chk("upd_delta", o_upd_delta, rsp_delta[k]);
            d = $urandom_range(1, 3);
            for (int w = 0; w < d; w++) begin
               i_solve_done = 1'b1;
               i_solve_fail = ($urandom_range(0, 1) == 1);
               @(negedge i_clk);
               i_solve_done = 1'b0;
               i_solve_fail = 1'b0;
               chk("upd_hold_pose", o_cur_pose, cur);
               chk("upd_hold_delta", o_upd_delta, rsp_delta[k]);
            end
            i_upd_done = 1'b1;
            i_upd_pose = rsp_pose[k];
            @(negedge i_clk);
            i_upd_done = 1'b0;
            i_upd_pose = rand_pose();
            cur        = rsp_pose[k];
            chk("check_gap", {o_solve_start, o_done, o_upd_start}, 0);
            @(negedge i_clk);
         end
      end
      chk("done", o_done, 1);
      chk("no_solve_at_done", o_solve_start, 0);
      chk("iter_total", o_iter_total, exp_total);
      chk("final_pose", o_cur_pose, exp_pose);
      @(negedge i_clk);
      chk("idle_busy", o_busy, 0);
      chk("done_one_cycle", o_done, 0);
      chk("pose_held", o_cur_pose, exp_pose);
   endtask

   task automatic chk_all_zero();
      chk("rst_busy", o_busy, 0);
      chk("rst_pulses", {o_solve_start, o_upd_start, o_done}, 0);
      chk("rst_total", o_iter_total, 0);
      chk("rst_level", o_solve_level, 0);
      chk("rst_pose", o_cur_pose, 0);
      chk("rst_delta", o_upd_delta, 0);
   endtask

   int exp_conv_total;

   initial begin
      i_rst_n      = 1'b0;
      i_start      = 1'b0;
      i_init_pose  = '0;
      i_max_iter   = '0;
      i_trans_thr  = '0;
      i_rot_thr    = '0;
      i_solve_done = 1'b0;
      i_solve_fail = 1'b0;
      i_delta_pose = '0;
      i_upd_done   = 1'b0;
      i_upd_pose   = '0;
      repeat (2) @(negedge i_clk);
      scen = "reset";
      chk_all_zero();
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Thresholds 0 never converge: two updates on every level.
      scen         = "max_iter2";
      cfg_max_iter = 4'd2;
      cfg_trans    = '0;
      cfg_rot      = '0;
      cfg_init     = rand_pose();
      fill_rsp(1'b1, 0);
      run_frame();
      chk("total_literal", o_iter_total, 6);

      // Stub delta converges with these thresholds when early exit is built in.
      scen         = "converge";
      cfg_max_iter = 4'd4;
      cfg_trans    = 32'd10;
      cfg_rot      = 32'd1;
      cfg_init     = rand_pose();
      fill_rsp(1'b1, 0);
      run_frame();
      exp_conv_total = CONV_EN ? 3 : 12;
      chk("total_literal", o_iter_total, exp_conv_total);

      scen         = "fail_first";
      cfg_max_iter = 4'd2;
      cfg_trans    = '0;
      cfg_rot      = '0;
      cfg_init     = rand_pose();
      fill_rsp(1'b1, 0);
      rsp_fail[0] = 1'b1;
      run_frame();
      chk("total_literal", o_iter_total, 4);

      scen         = "max_iter0";
      cfg_max_iter = 4'd0;
      cfg_init     = rand_pose();
      fill_rsp(1'b1, 0);
      run_frame();

      // Reset while waiting on UpdatePose.
      scen        = "reset_wait_upd";
      i_init_pose = rand_pose();
      i_max_iter  = 4'd3;
      i_start     = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      @(negedge i_clk);
      i_solve_done = 1'b1;
      i_delta_pose = stub_delta();
      @(negedge i_clk);
      i_solve_done = 1'b0;
      chk("upd_start_pre_reset", o_upd_start, 1);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      chk_all_zero();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("no_done_after_reset", {o_done, o_busy}, 0);

      scen         = "after_reset";
      cfg_max_iter = 4'd1;
      cfg_trans    = '0;
      cfg_rot      = '0;
      cfg_init     = rand_pose();
      fill_rsp(1'b1, 0);
      run_frame();

      scen = "random";
      for (int f = 0; f < 12; f++) begin
         cfg_max_iter = ITER_BW'($urandom_range(0, 5));
         cfg_trans    = POSE_BW'($urandom_range(0, 25));
         cfg_rot      = POSE_BW'($urandom_range(0, 25));
         cfg_init     = rand_pose();
         fill_rsp(1'b0, 20);
         run_frame();
         repeat ($urandom_range(0, 2)) @(negedge i_clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
